fpmul_issue_ctrl: RTL and testbench

FPMUL_ISSUE_CTRL -- requirements
Module: fpmul_issue_ctrl

---
 rtl/fpmul_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_fpmul_issue_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_issue_ctrl.sv
// Issue/result sequencer wrapping a multi-cycle FPMUL: IDLE -> CLR -> START -> WAIT -> HOLD.
// Optional macro FPMUL_TIMEOUT_EN adds a WAIT watchdog that returns a quiet-NaN error result.
module fpmul_issue_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        In_Valid,
   output logic        In_Ready,
   input  logic [31:0] In_A,
   input  logic [31:0] In_B,
   output logic [31:0] Mul_A,
   output logic [31:0] Mul_B,
   output logic        Mul_Start,
   output logic        Mul_Rst,
   input  logic [31:0] Mul_P,
   input  logic [5:0]  Mul_Flags,
   input  logic        Mul_Done,
   output logic        Res_Valid,
   input  logic        Res_Ready,
   output logic [31:0] Res_P,
   output logic [5:0]  Res_Flags,
   output logic        Res_Err,
   output logic        Busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] p_q, p_d;
   logic [5:0]  f_q, f_d;

   generate
      if (TIMEOUT < 1) begin : g_bad_timeout
         $error("fpmul_issue_ctrl: TIMEOUT must be at least 1");
      end
   endgenerate

`ifdef FPMUL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         f_q     <= '0;
`ifdef FPMUL_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         f_q     <= f_d;
`ifdef FPMUL_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      f_d     = f_q;
`ifdef FPMUL_TIMEOUT_EN
      err_d   = err_q;
      cnt_d   = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (In_Valid) begin
               a_d     = In_A;
               b_d     = In_B;
               state_d = S_CLR;
            end
         end
         S_CLR:   state_d = S_START;
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            // Done wins over a coinciding watchdog expiry.
            if (Mul_Done) begin
               p_d     = Mul_P;
               f_d     = Mul_Flags;
`ifdef FPMUL_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = S_HOLD;
            end
`ifdef FPMUL_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               p_d     = 32'h7FC0_0000;
               f_d     = 6'b001000;
               err_d   = 1'b1;
               state_d = S_HOLD;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
`endif
         end
         S_HOLD: begin
            if (Res_Ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Ready is masked by Rst so it stays low for the whole reset pulse.
   assign In_Ready  = (state_q == S_IDLE) && !Rst;
   assign Mul_A     = a_q;
   assign Mul_B     = b_q;
   assign Mul_Rst   = (state_q == S_CLR);
   assign Mul_Start = (state_q == S_START);
   assign Res_Valid = (state_q == S_HOLD);
   assign Res_P     = p_q;
   assign Res_Flags = f_q;
   assign Busy      = (state_q != S_IDLE);
`ifdef FPMUL_TIMEOUT_EN
   assign Res_Err   = err_q;
`else
   assign Res_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_fpmul_issue_ctrl.sv
// Self-checking bench for fpmul_issue_ctrl: behavioural FPMUL with sticky Done plus directed and random ops.
`timescale 1ns/1ps
module tb_fpmul_issue_ctrl;

   localparam int TO = 15;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        In_Valid = 1'b0;
   logic        In_Ready;
   logic [31:0] In_A = '0;
   logic [31:0] In_B = '0;
   logic [31:0] Mul_A, Mul_B;
   logic        Mul_Start, Mul_Rst;
   logic [31:0] Mul_P = '0;
   logic [5:0]  Mul_Flags = '0;
   logic        Mul_Done = 1'b0;
   logic        Res_Valid;
   logic        Res_Ready = 1'b0;
   logic [31:0] Res_P;
   logic [5:0]  Res_Flags;
   logic        Res_Err;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   // FPMUL behavioural model: product appears lat cycles after Start, Done sticky until Mul_Rst.
   int          model_lat = 4;
   logic [31:0] model_p   = '0;
   logic [5:0]  model_f   = '0;
   int          mcnt      = 0;

   fpmul_issue_ctrl #(.TIMEOUT(TO)) dut (
      .Clk(Clk), .Rst(Rst),
      .In_Valid(In_Valid), .In_Ready(In_Ready), .In_A(In_A), .In_B(In_B),
      .Mul_A(Mul_A), .Mul_B(Mul_B), .Mul_Start(Mul_Start), .Mul_Rst(Mul_Rst),
      .Mul_P(Mul_P), .Mul_Flags(Mul_Flags), .Mul_Done(Mul_Done),
      .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Res_P(Res_P),
      .Res_Flags(Res_Flags), .Res_Err(Res_Err), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk or posedge Rst) begin
      if (Rst || Mul_Rst) begin
         Mul_Done <= 1'b0;
         mcnt     <= 0;
      end else if (Mul_Start) begin
         mcnt <= model_lat;
      end else if (mcnt > 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1) begin
            Mul_Done  <= 1'b1;
            Mul_P     <= model_p;
            Mul_Flags <= model_f;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string where);
      check({where, "_in_ready"},  In_Ready,  0);
      check({where, "_mul_a"},     Mul_A,     0);
      check({where, "_mul_b"},     Mul_B,     0);
      check({where, "_mul_start"}, Mul_Start, 0);
      check({where, "_mul_rst"},   Mul_Rst,   0);
      check({where, "_res_valid"}, Res_Valid, 0);
      check({where, "_res_p"},     Res_P,     0);
      check({where, "_res_flags"}, Res_Flags, 0);
      check({where, "_res_err"},   Res_Err,   0);
      check({where, "_busy"},      Busy,      0);
   endtask

   // One complete operation; lat==0 means the FPMUL never reports Done.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                        input logic [5:0] f, input int lat, input int bp);
      int          c, k, nrst, nstart, rst_at, start_at, overlap, rdy_hi, a_bad, bad, exp_c;
      bit          timed_out;
      logic [31:0] exp_p;
      logic [5:0]  exp_f;
      logic        exp_err;

`ifdef FPMUL_TIMEOUT_EN
      timed_out = (lat == 0) || (lat + 1 > TO);
`else
      timed_out = 1'b0;
`endif
      exp_c   = timed_out ? TO + 2 : lat + 3;
      exp_p   = timed_out ? 32'h7FC0_0000 : p;
      exp_f   = timed_out ? 6'b001000 : f;
      exp_err = timed_out;

      k = 0;
      while (!In_Ready && k < 50) begin
         tick();
         k++;
      end
      check("in_ready_idle", In_Ready, 1);
      model_p   = p;
      model_f   = f;
      model_lat = lat;
      In_A      = a;
      In_B      = b;
      In_Valid  = 1'b1;
      tick();
      In_Valid = 1'b0;
      In_A     = $urandom;
      In_B     = $urandom;

      c = 0; nrst = 0; nstart = 0; rst_at = -1; start_at = -1;
      overlap = 0; rdy_hi = 0; a_bad = 0;
      while (!Res_Valid && c < 100) begin
         if (Mul_Rst) begin nrst++; if (rst_at < 0) rst_at = c; end
         if (Mul_Start) begin nstart++; if (start_at < 0) start_at = c; end
         if (Mul_Rst && Mul_Start) overlap++;
         if (In_Ready) rdy_hi++;
         if (Mul_A !== a || Mul_B !== b) a_bad++;
         tick();
         c++;
      end
      check("res_valid_seen", Res_Valid, 1);
      check("latency", c, exp_c);
      check("mul_rst_count", nrst, 1);
      check("mul_start_count", nstart, 1);
      check("mul_rst_cycle", rst_at, 0);
      check("mul_start_cycle", start_at, 1);
      check("rst_start_overlap", overlap, 0);
      check("in_ready_while_busy", rdy_hi, 0);
      check("operands_stable", a_bad, 0);
      check("res_p", Res_P, exp_p);
      check("res_flags", Res_Flags, exp_f);
      check("res_err", Res_Err, exp_err);
      check("busy_hold", Busy, 1);

      bad = 0;
      for (int i = 0; i < bp; i++) begin
         tick();
         if (Res_Valid !== 1'b1 || Res_P !== exp_p || Res_Flags !== exp_f ||
             Res_Err !== exp_err || In_Ready !== 1'b0) bad++;
      end
      check("backpressure_stable", bad, 0);

      // Offer a new operand in the accept cycle: it must not be taken.
      Res_Ready = 1'b1;
      In_Valid  = 1'b1;
      In_A      = ~a;
      In_B      = ~b;
      tick();
      In_Valid  = 1'b0;
      Res_Ready = 1'b0;
      check("accept_res_valid", Res_Valid, 0);
      check("accept_idle", Busy, 0);
      check("no_bypass_a", Mul_A, a);
      check("no_bypass_b", Mul_B, b);
      check("res_p_retained", Res_P, exp_p);
      check("res_flags_retained", Res_Flags, exp_f);
      $display("op a=%h b=%h lat=%0d bp=%0d -> latency=%0d p=%h flags=%b err=%0d",
               a, b, lat, bp, c, Res_P, Res_Flags, Res_Err);
   endtask

   initial begin
      int k, vcount;

      // Reset state while Rst is held.
      tick();
      tick();
      check_reset_outputs("por");
      Rst = 1'b0;
      #1;
      check("in_ready_after_reset", In_Ready, 1);
      $display("reset released, In_Ready=%0d", In_Ready);

      // Basic 3.0 * 2.0 = 6.0.
      do_op(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 6'b000000, 4, 0);
      // Backpressure for 10 cycles.
      do_op(32'h3F80_0000, 32'h4080_0000, 32'h4080_0000, 6'b000000, 4, 10);
      // Sticky Done across back-to-back operations.
      do_op(32'h4100_0000, 32'h4100_0000, 32'h4280_0000, 6'b000000, 4, 0);
      do_op(32'h4120_0000, 32'h4120_0000, 32'h42C8_0000, 6'b000000, 6, 0);
      // Overflow/Inf flags pass through.
      do_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 6'b100100, 3, 1);

      // Reset two cycles after Mul_Start.
      model_lat = 6;
      k = 0;
      while (!In_Ready && k < 50) begin tick(); k++; end
      In_A = 32'h1234_5678;
      In_B = 32'h9ABC_DEF0;
      In_Valid = 1'b1;
      tick();
      In_Valid = 1'b0;
      k = 0;
      while (!Mul_Start && k < 20) begin tick(); k++; end
      check("midwait_start_seen", Mul_Start, 1);
      tick();
      tick();
      Rst = 1'b1;
      #1;
      check_reset_outputs("midwait");
      tick();
      tick();
      Rst = 1'b0;
      #1;
      check("midwait_in_ready", In_Ready, 1);
      vcount = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (Res_Valid || Busy) vcount++;
      end
      check("midwait_no_result", vcount, 0);
      $display("reset mid-WAIT applied, spurious activity cycles=%0d", vcount);
      do_op(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 6'b000000, 2, 2);

`ifdef FPMUL_TIMEOUT_EN
      do_op(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 6'b000000, 0, 2);
      do_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 6'b000001, TO - 1, 0);
      do_op(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 6'b000010, TO, 0);
`endif

      // Random operations.
      for (int n = 0; n < 25; n++) begin
         logic [31:0] ra, rb, rp;
         logic [5:0]  rf;
         int          rl;
         ra = $urandom;
         rb = $urandom;
         rp = $urandom;
         rf = 6'($urandom);
         rl = $urandom_range(1, 6);
`ifdef FPMUL_TIMEOUT_EN
         if ($urandom_range(0, 5) == 0) rl = $urandom_range(0, TO + 2);
`endif
         do_op(ra, rb, rp, rf, rl, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
